// File: rtl/adc_capture_sdram_master.sv
// Multi-channel ADC capture into SDRAM over a req/ack port, then optional readback stream.
// Requests are registered and held until ack; one read outstanding; a held ADC set blocks new sets (overrun).
module adc_capture_sdram_master #(
   parameter int DATA_W = 16,
   parameter int NUM_CH = 4,
   parameter int DEPTH = 128,
   parameter int ADDR_W = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                                        clk,
   input  logic                                        reset_n,
   input  logic                                        start,
   input  logic                                        stop,
   input  logic                                        mode,
   input  logic                                        adc_valid,
   input  logic [NUM_CH*DATA_W-1:0]                    adc_data,
   output logic                                        sdram_req,
   output logic                                        sdram_rw,
   output logic [ADDR_W-1:0]                           sdram_addr,
   output logic [DATA_W-1:0]                           sdram_wdata,
   output logic [1:0]                                  sdram_byte_sel,
   input  logic                                        sdram_ack,
   input  logic                                        sdram_rvalid,
   input  logic [DATA_W-1:0]                           sdram_rdata,
   output logic                                        rd_valid,
   output logic [DATA_W-1:0]                           rd_data,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
   output logic                                        init,
   output logic                                        busy,
   output logic                                        done,
   output logic                                        overrun,
   output logic                                        wrapped
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int SET_W = $clog2(DEPTH);
   localparam int WORDS = DEPTH * NUM_CH;
   localparam int CNT_W = $clog2(WORDS);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAP, S_READ} state_t;
   state_t state, state_nxt;

   logic                     start_prev;
   logic                     cont_mode;
   logic                     hold_vld;
   logic [NUM_CH*DATA_W-1:0] hold_dat;
   logic [SET_W-1:0]         set_idx;
   logic [SET_W-1:0]         set_nxt;
   logic [CH_W-1:0]          ch_idx;
   logic [CH_W-1:0]          ch_nxt;
   logic [CNT_W-1:0]         rd_cnt;
   logic [CH_W-1:0]          rd_ch_idx;
   logic                     rd_pend;
   logic                     start_edge;
   logic                     wr_ack;
   logic                     last_ack;
   logic                     set_last;
   logic                     accept;
   logic                     rd_done;

   function automatic logic [ADDR_W-1:0] wr_addr(input logic [SET_W-1:0] s, input logic [CH_W-1:0] c);
      return BASE_ADDR + ADDR_W'(s) * ADDR_W'(NUM_CH) + ADDR_W'(c);
   endfunction

   assign sdram_byte_sel = 2'b11;
   assign start_edge = start_prev && !start;
   assign wr_ack     = (state == S_CAP) && sdram_req && sdram_ack;
   assign last_ack   = wr_ack && (ch_idx == CH_W'(NUM_CH - 1));
   assign set_last   = (set_idx == SET_W'(DEPTH - 1));
   assign set_nxt    = set_last ? '0 : set_idx + 1'b1;
   assign ch_nxt     = ch_idx + 1'b1;
   // The holding register frees on the last channel ack, so a set arriving that cycle still fits.
   assign accept     = (state == S_CAP) && adc_valid && (!hold_vld || last_ack) &&
                       (cont_mode ? !stop : !(last_ack && set_last));
   assign rd_done    = (state == S_READ) && rd_pend && sdram_rvalid && (rd_cnt == CNT_W'(WORDS - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start_edge) state_nxt = S_ARM;
         S_ARM:  state_nxt = S_CAP;
         S_CAP: begin
            if (!cont_mode && last_ack && set_last)     state_nxt = S_READ;
            else if (cont_mode && stop && !hold_vld)    state_nxt = S_IDLE;
         end
         S_READ: if (rd_done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         start_prev  <= 1'b1;
         cont_mode   <= 1'b0;
         hold_vld    <= 1'b0;
         hold_dat    <= '0;
         set_idx     <= '0;
         ch_idx      <= '0;
         rd_cnt      <= '0;
         rd_ch_idx   <= '0;
         rd_pend     <= 1'b0;
         sdram_req   <= 1'b0;
         sdram_rw    <= 1'b0;
         sdram_addr  <= '0;
         sdram_wdata <= '0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         rd_ch       <= '0;
         init        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
         wrapped     <= 1'b0;
      end else begin
         start_prev <= start;
         init       <= 1'b0;
         done       <= 1'b0;
         rd_valid   <= 1'b0;
         busy       <= (state_nxt != S_IDLE);
         if (state != S_IDLE && state_nxt == S_IDLE) done <= 1'b1;
         case (state)
            S_IDLE: begin
               if (state_nxt == S_ARM) begin
                  init     <= 1'b1;
                  set_idx  <= '0;
                  ch_idx   <= '0;
                  overrun  <= 1'b0;
                  wrapped  <= 1'b0;
                  hold_vld <= 1'b0;
               end
            end
            S_ARM: cont_mode <= mode;
            S_CAP: begin
               if (wr_ack) begin
                  if (last_ack) begin
                     hold_vld  <= 1'b0;
                     sdram_req <= 1'b0;
                     ch_idx    <= '0;
                     set_idx   <= set_nxt;
                     if (set_last && cont_mode) wrapped <= 1'b1;
                  end else begin
                     ch_idx      <= ch_nxt;
                     sdram_addr  <= wr_addr(set_idx, ch_nxt);
                     sdram_wdata <= hold_dat[ch_nxt*DATA_W +: DATA_W];
                  end
               end
               if (accept) begin
                  hold_vld    <= 1'b1;
                  hold_dat    <= adc_data;
                  sdram_req   <= 1'b1;
                  sdram_rw    <= 1'b1;
                  ch_idx      <= '0;
                  sdram_addr  <= wr_addr(last_ack ? set_nxt : set_idx, '0);
                  sdram_wdata <= adc_data[DATA_W-1:0];
               end else if (adc_valid && hold_vld && !last_ack && !(cont_mode && stop)) begin
                  overrun <= 1'b1;
               end
               if (state_nxt == S_READ) begin
                  sdram_req   <= 1'b1;
                  sdram_rw    <= 1'b0;
                  sdram_addr  <= BASE_ADDR;
                  sdram_wdata <= '0;
                  rd_cnt      <= '0;
                  rd_ch_idx   <= '0;
                  rd_pend     <= 1'b1;
               end
            end
            S_READ: begin
               if (sdram_req && sdram_ack) sdram_req <= 1'b0;
               if (rd_pend && sdram_rvalid) begin
                  rd_valid  <= 1'b1;
                  rd_data   <= sdram_rdata;
                  rd_ch     <= rd_ch_idx;
                  rd_ch_idx <= (rd_ch_idx == CH_W'(NUM_CH - 1)) ? '0 : rd_ch_idx + 1'b1;
                  if (rd_done) begin
                     rd_pend <= 1'b0;
                  end else begin
                     rd_cnt     <= rd_cnt + 1'b1;
                     sdram_req  <= 1'b1;
                     sdram_addr <= BASE_ADDR + ADDR_W'(rd_cnt + 1'b1);
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_capture_sdram_master.sv
// Bench for adc_capture_sdram_master (NUM_CH=2, DEPTH=4): scoreboarded writes and readback.
module tb_adc_capture_sdram_master;
   localparam int DW = 16;
   localparam int NCH = 2;
   localparam int DEP = 4;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            start = 1'b1;
   logic            stop = 1'b0;
   logic            mode = 1'b0;
   logic            adc_valid = 1'b0;
   logic [NCH*DW-1:0] adc_data = '0;
   logic            sdram_req, sdram_rw;
   logic [AW-1:0]   sdram_addr;
   logic [DW-1:0]   sdram_wdata;
   logic [1:0]      sdram_byte_sel;
   logic            sdram_ack = 1'b0;
   logic            sdram_rvalid = 1'b0;
   logic [DW-1:0]   sdram_rdata = '0;
   logic            rd_valid;
   logic [DW-1:0]   rd_data;
   logic [0:0]      rd_ch;
   logic            init, busy, done, overrun, wrapped;

   adc_capture_sdram_master #(.DATA_W(DW), .NUM_CH(NCH), .DEPTH(DEP), .ADDR_W(AW), .BASE_ADDR('0)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
      .adc_valid(adc_valid), .adc_data(adc_data),
      .sdram_req(sdram_req), .sdram_rw(sdram_rw), .sdram_addr(sdram_addr),
      .sdram_wdata(sdram_wdata), .sdram_byte_sel(sdram_byte_sel), .sdram_ack(sdram_ack),
      .sdram_rvalid(sdram_rvalid), .sdram_rdata(sdram_rdata),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ch(rd_ch),
      .init(init), .busy(busy), .done(done), .overrun(overrun), .wrapped(wrapped));

   always #5 clk = ~clk;

   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
   typedef struct { logic [DW-1:0] data; logic [0:0] ch; } rd_t;
   wr_t wq[$];
   rd_t rq[$];

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int init_cnt = 0;
   int wait_cnt = 0;
   int ack_lat = 0;
   logic ack_block = 1'b0;
   logic rd_sched = 1'b0;
   logic [DW-1:0] rd_word = '0;
   logic [DW-1:0] mem [0:255];

   // SDRAM model: ack after ack_lat waiting cycles, read data one cycle after ack.
   always @(posedge clk) begin
      #1;
      sdram_ack    = sdram_req && !ack_block && (wait_cnt >= ack_lat);
      sdram_rvalid = rd_sched;
      sdram_rdata  = rd_sched ? rd_word : '0;
      rd_sched     = 1'b0;
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (done) done_cnt++;
         if (init) init_cnt++;
         if (sdram_req && sdram_ack) begin
            wait_cnt = 0;
            if (sdram_rw) begin
               mem[sdram_addr[7:0]] = sdram_wdata;
               total++;
               if (wq.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_write addr=%h data=%h", sdram_addr, sdram_wdata);
               end else begin
                  wr_t e;
                  e = wq.pop_front();
                  if (sdram_addr !== e.addr || sdram_wdata !== e.data) begin
                     bad++;
                     $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                              sdram_addr, sdram_wdata, e.addr, e.data);
                  end
               end
            end else begin
               rd_sched = 1'b1;
               rd_word  = mem[sdram_addr[7:0]];
            end
         end else if (sdram_req) begin
            wait_cnt++;
         end
         if (rd_valid) begin
            total++;
            if (rq.size() == 0) begin
               bad++;
               $display("FAIL unexpected_rd_valid data=%h ch=%0d", rd_data, rd_ch);
            end else begin
               rd_t r;
               r = rq.pop_front();
               if (rd_data !== r.data || rd_ch !== r.ch) begin
                  bad++;
                  $display("FAIL readback got data=%h ch=%0d want data=%h ch=%0d", rd_data, rd_ch, r.data, r.ch);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_set(input int set, input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit rd);
      wq.push_back('{addr: AW'(set*2), data: d0});
      wq.push_back('{addr: AW'(set*2 + 1), data: d1});
      if (rd) begin
         rq.push_back('{data: d0, ch: 1'b0});
         rq.push_back('{data: d1, ch: 1'b1});
      end
   endtask

   task automatic pulse(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      adc_valid = 1'b1;
      adc_data  = {d1, d0};
      tick();
      adc_valid = 1'b0;
   endtask

   task automatic do_start(input logic m);
      start = 1'b1;
      tick();
      mode  = m;
      start = 1'b0;
      tick();
      total++;
      if (init !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL start_latency init=%b busy=%b want 1 1", init, busy);
      end
      start = 1'b1;
      tick();
      total++;
      if (init !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL init_width init=%b busy=%b want 0 1", init, busy);
      end
   endtask

   task automatic wait_idle(input int max_cyc, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s_timeout busy=%b want 0 within %0d cycles", name, busy, max_cyc);
      end
      tick();
      tick();
   endtask

   task automatic check_drained(input string name);
      total++;
      if (wq.size() != 0 || rq.size() != 0) begin
         bad++;
         $display("FAIL %s_drained writes_left=%0d reads_left=%0d want 0 0", name, wq.size(), rq.size());
      end
   endtask

   task automatic check_outputs_zero(input string name);
      total++;
      if ({sdram_req, sdram_rw, sdram_addr, sdram_wdata, rd_valid, rd_data, rd_ch,
           init, busy, done, overrun, wrapped} !== '0) begin
         bad++;
         $display("FAIL %s req=%b rw=%b addr=%h wdata=%h rdv=%b rdd=%h ch=%b init=%b busy=%b done=%b ovr=%b wrap=%b want all 0",
                  name, sdram_req, sdram_rw, sdram_addr, sdram_wdata, rd_valid, rd_data, rd_ch,
                  init, busy, done, overrun, wrapped);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      check_outputs_zero("reset_state");
      reset_n = 1'b1;
      tick();
      check_outputs_zero("after_reset_idle");
   endtask

   task automatic test_single_shot(input logic [DW-1:0] b0, input logic [DW-1:0] b1, input string name);
      int d0;
      ack_lat = 0;
      d0 = done_cnt;
      do_start(1'b0);
      for (int n = 0; n < DEP; n++) begin
         push_set(n, b0 + DW'(n), b1 + DW'(n), 1'b1);
         pulse(b0 + DW'(n), b1 + DW'(n));
         if (n == 0) begin
            total++;
            if (sdram_req !== 1'b1 || sdram_rw !== 1'b1 || sdram_addr !== 32'd0 ||
                sdram_wdata !== b0 || sdram_byte_sel !== 2'b11) begin
               bad++;
               $display("FAIL %s_first_req req=%b rw=%b addr=%h wdata=%h bsel=%b want 1 1 0 %h 11",
                        name, sdram_req, sdram_rw, sdram_addr, sdram_wdata, sdram_byte_sel, b0);
            end
         end
         tick(); tick(); tick();
      end
      wait_idle(200, name);
      check_drained(name);
      total++;
      if (done_cnt - d0 != 1 || overrun !== 1'b0 || wrapped !== 1'b0) begin
         bad++;
         $display("FAIL %s_flags done_pulses=%0d overrun=%b wrapped=%b want 1 0 0", name, done_cnt - d0, overrun, wrapped);
      end
   endtask

   task automatic test_overrun();
      ack_lat = 3;
      do_start(1'b0);
      // With 4-cycle writes a set holds the register for 8 cycles: every 4th 2-cycle pulse fits.
      for (int i = 0; i < 13; i++) begin
         if (i % 4 == 0) push_set(i / 4, 16'hC000 + DW'(i), 16'hD000 + DW'(i), 1'b1);
         pulse(16'hC000 + DW'(i), 16'hD000 + DW'(i));
         tick();
      end
      wait_idle(400, "overrun");
      check_drained("overrun");
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_flag overrun=%b want 1", overrun);
      end
      ack_lat = 0;
   endtask

   task automatic test_continuous();
      int d0;
      ack_lat = 0;
      d0 = done_cnt;
      do_start(1'b1);
      for (int n = 0; n < 6; n++) begin
         push_set(n % DEP, 16'hE000 + DW'(n), 16'hE100 + DW'(n), 1'b0);
         pulse(16'hE000 + DW'(n), 16'hE100 + DW'(n));
         if (n == 5) stop = 1'b1;
         tick(); tick(); tick();
      end
      wait_idle(100, "continuous");
      stop = 1'b0;
      check_drained("continuous");
      total++;
      if (wrapped !== 1'b1 || overrun !== 1'b0 || done_cnt - d0 != 1) begin
         bad++;
         $display("FAIL continuous_flags wrapped=%b overrun=%b done_pulses=%0d want 1 0 1", wrapped, overrun, done_cnt - d0);
      end
      total++;
      if (mem[0] !== 16'hE004 || mem[1] !== 16'hE104 || mem[2] !== 16'hE005) begin
         bad++;
         $display("FAIL ring_overwrite mem0=%h mem1=%h mem2=%h want e004 e104 e005", mem[0], mem[1], mem[2]);
      end
   endtask

   task automatic test_back_pressure();
      int i0;
      ack_lat = 0;
      ack_block = 1'b1;
      do_start(1'b0);
      i0 = init_cnt;
      push_set(0, 16'hF000, 16'hF100, 1'b1);
      pulse(16'hF000, 16'hF100);
      for (int c = 0; c < 10; c++) begin
         total++;
         if ({sdram_req, sdram_rw, sdram_addr, sdram_wdata} !== {1'b1, 1'b1, 32'd0, 16'hF000}) begin
            bad++;
            $display("FAIL stall_stable cyc=%0d req=%b rw=%b addr=%h wdata=%h want 1 1 0 f000",
                     c, sdram_req, sdram_rw, sdram_addr, sdram_wdata);
         end
         if (c == 3) start = 1'b0;
         tick();
      end
      ack_block = 1'b0;
      tick(); tick(); tick(); tick();
      for (int n = 1; n < DEP; n++) begin
         push_set(n, 16'hF000 + DW'(n), 16'hF100 + DW'(n), 1'b1);
         pulse(16'hF000 + DW'(n), 16'hF100 + DW'(n));
         tick(); tick(); tick();
      end
      wait_idle(200, "back_pressure");
      check_drained("back_pressure");
      for (int c = 0; c < 5; c++) tick();
      total++;
      if (busy !== 1'b0 || init_cnt != i0) begin
         bad++;
         $display("FAIL start_ignored busy=%b extra_init=%0d want 0 0", busy, init_cnt - i0);
      end
      start = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_cap();
      ack_block = 1'b1;
      do_start(1'b0);
      pulse(16'h1234, 16'h5678);
      tick();
      total++;
      if (sdram_req !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_req req=%b want 1", sdram_req);
      end
      reset_n = 1'b0;
      tick();
      check_outputs_zero("reset_mid_cap");
      wq.delete();
      rq.delete();
      wait_cnt = 0;
      ack_block = 1'b0;
      reset_n = 1'b1;
      tick();
      test_single_shot(16'h7000, 16'h7100, "restart");
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = '0;
      test_reset();
      test_single_shot(16'hA000, 16'hB000, "single_shot");
      test_overrun();
      test_continuous();
      test_back_pressure();
      test_reset_mid_cap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout reached");
      $fatal(1);
   end
endmodule
